mode7_scanline_setup: RTL and testbench

//  Per-scanline setup engine for the mode-7 floor renderer. It sits upstream of the pixel stepper.
//  It takes the per-frame frustum corners and a per-line 1/(y-240) factor.

---
 rtl/mode7_scanline_setup_if.sv | 29 ++
 rtl/mode7_scanline_setup.sv | 192 +++++++++++++++++++
 tb/tb_mode7_scanline_setup.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mode7_scanline_setup_if.sv
// Bus interface for the mode-7 scanline setup engine.
// Carries the frame corner load, the per-line start request with its 1/(y-240)
// factor, and the busy/valid status together with the edge and stride results.
//   master : producer of corners/start, consumer of results (renderer control)
//   slave  : the setup engine itself
interface mode7_scanline_setup_if #(
    parameter int CW = 29,
    parameter int EW = 36,
    parameter int SW = 33
);
    logic                 frame_load;
    logic signed [CW-1:0] a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v;
    logic                 start;
    logic        [16:0]   one_over_y;
    logic                 busy;
    logic                 valid;
    logic signed [EW-1:0] left_u, left_v, right_u, right_v;
    logic signed [SW-1:0] u_stride, v_stride;

    modport master (
        output frame_load, a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v, start, one_over_y,
        input  busy, valid, left_u, left_v, right_u, right_v, u_stride, v_stride
    );

    modport slave (
        input  frame_load, a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v, start, one_over_y,
        output busy, valid, left_u, left_v, right_u, right_v, u_stride, v_stride
    );
endinterface

// File: rtl/mode7_scanline_setup.sv
// Per-scanline setup for the mode-7 floor renderer.
// Interpolates the left/right texture-space edge points between the frame corners
// using the line's 1/(y-240) factor, then derives the u/v per-pixel strides. A single
// multiplier is shared across the six products, one per cycle during hblank.
// Ports:
//   clk  : pixel clock
//   rst  : synchronous reset, active-high
//   bus  : slave side of mode7_scanline_setup_if (corners, start, results)
//
// state      | meaning
// -----------+-------------------------------------------------
// S_IDLE     | waiting for start; corner loads go straight in
// S_EDGE0..3 | left_u, left_v, right_u, right_v into staging
// S_STRIDE0  | u_stride into staging
// S_STRIDE1  | v_stride; all six results move to the outputs
// S_DONE     | valid pulse; pending corner load is applied
module mode7_scanline_setup #(
    parameter int         CW        = 29,
    parameter int         EW        = 36,
    parameter int         SW        = 33,
    parameter logic [7:0] INV_WIDTH = 8'd102
) (
    input  logic                   clk,
    input  logic                   rst,
    mode7_scanline_setup_if.slave  bus
);
    localparam int MW = EW + 9;   // span width for the stride product
    localparam int PW = 16 + SW;  // multiplier width: enough for stride bits [PW-1:16]

    typedef enum logic [2:0] {
        S_IDLE, S_EDGE0, S_EDGE1, S_EDGE2, S_EDGE3, S_STRIDE0, S_STRIDE1, S_DONE
    } state_t;

    state_t state, state_next;

    // corner order: a_u a_v b_u b_v c_u c_v d_u d_v
    logic [CW-1:0] corn_in [8];
    logic [CW-1:0] corn    [8];
    logic [CW-1:0] shadow  [8];
    logic          pending;
    logic [16:0]   oy;

    logic [EW-1:0] st_lu, st_lv, st_ru, st_rv;
    logic [SW-1:0] st_su;
    logic [EW-1:0] out_lu, out_lv, out_ru, out_rv;
    logic [SW-1:0] out_su, out_sv;

    logic [CW-1:0]        hi, lo;
    logic signed [CW:0]   diff_sh;
    logic [MW-1:0]        span;
    logic [PW-1:0]        mul_a, mul_b, prod;
    logic [EW-1:0]        edge_res;
    logic [SW-1:0]        stride_res;

    assign corn_in[0] = bus.a_u;
    assign corn_in[1] = bus.a_v;
    assign corn_in[2] = bus.b_u;
    assign corn_in[3] = bus.b_v;
    assign corn_in[4] = bus.c_u;
    assign corn_in[5] = bus.c_v;
    assign corn_in[6] = bus.d_u;
    assign corn_in[7] = bus.d_v;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b1;
        bus.valid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_next = S_EDGE0;
            end
            S_EDGE0:   state_next = S_EDGE1;
            S_EDGE1:   state_next = S_EDGE2;
            S_EDGE2:   state_next = S_EDGE3;
            S_EDGE3:   state_next = S_STRIDE0;
            S_STRIDE0: state_next = S_STRIDE1;
            S_STRIDE1: state_next = S_DONE;
            S_DONE: begin
                bus.valid  = 1'b1;
                state_next = S_IDLE;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    // Far corner (hi) and near corner (lo) for the current edge term.
    always_comb begin
        hi = '0;
        lo = '0;
        unique case (state)
            S_EDGE0: begin hi = corn[0]; lo = corn[4]; end
            S_EDGE1: begin hi = corn[1]; lo = corn[5]; end
            S_EDGE2: begin hi = corn[2]; lo = corn[6]; end
            S_EDGE3: begin hi = corn[3]; lo = corn[7]; end
            default: ;
        endcase
    end

    // Difference needs one extra bit so opposite-sign corners cannot wrap before the shift.
    assign diff_sh = ($signed({hi[CW-1], hi}) - $signed({lo[CW-1], lo})) >>> 16;

    always_comb begin
        span = '0;
        if (state == S_STRIDE1)
            span = {{9{st_rv[EW-1]}}, st_rv} - {{9{st_lv[EW-1]}}, st_lv};
        else
            span = {{9{st_ru[EW-1]}}, st_ru} - {{9{st_lu[EW-1]}}, st_lu};
    end

    // Operands are sign-extended to PW so an unsigned multiply yields the correct low PW bits.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == S_STRIDE0 || state == S_STRIDE1) begin
            mul_a = {{(PW-MW){span[MW-1]}}, span};
            mul_b = {{(PW-8){INV_WIDTH[7]}}, INV_WIDTH};
        end else begin
            mul_a = {{(PW-CW-1){diff_sh[CW]}}, diff_sh};
            mul_b = {{(PW-17){1'b0}}, oy};
        end
    end

    assign prod       = mul_a * mul_b;
    assign edge_res   = prod[EW-1:0] + {{(EW-CW){lo[CW-1]}}, lo};
    assign stride_res = prod[PW-1:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                corn[i]   <= '0;
                shadow[i] <= '0;
            end
            pending <= 1'b0;
            oy      <= '0;
            st_lu   <= '0;
            st_lv   <= '0;
            st_ru   <= '0;
            st_rv   <= '0;
            st_su   <= '0;
            out_lu  <= '0;
            out_lv  <= '0;
            out_ru  <= '0;
            out_rv  <= '0;
            out_su  <= '0;
            out_sv  <= '0;
        end else begin
            unique case (state)
                S_IDLE:    if (bus.start) oy <= bus.one_over_y;
                S_EDGE0:   st_lu <= edge_res;
                S_EDGE1:   st_lv <= edge_res;
                S_EDGE2:   st_ru <= edge_res;
                S_EDGE3:   st_rv <= edge_res;
                S_STRIDE0: st_su <= stride_res;
                S_STRIDE1: begin
                    out_lu <= st_lu;
                    out_lv <= st_lv;
                    out_ru <= st_ru;
                    out_rv <= st_rv;
                    out_su <= st_su;
                    out_sv <= stride_res;
                end
                default: ;
            endcase

            // Corners change only between lines; a load during a line is held in the
            // shadow and applied as DONE retires, so a start in the following cycle sees it.
            if (state == S_IDLE) begin
                if (bus.frame_load) corn <= corn_in;
            end else if (state == S_DONE) begin
                if (bus.frame_load) corn <= corn_in;
                else if (pending)   corn <= shadow;
                pending <= 1'b0;
            end else if (bus.frame_load) begin
                shadow  <= corn_in;
                pending <= 1'b1;
            end
        end
    end

    assign bus.left_u   = out_lu;
    assign bus.left_v   = out_lv;
    assign bus.right_u  = out_ru;
    assign bus.right_v  = out_rv;
    assign bus.u_stride = out_su;
    assign bus.v_stride = out_sv;
endmodule

// File: tb/tb_mode7_scanline_setup.sv
// Self-checking bench for mode7_scanline_setup: expected results are pushed to a
// scoreboard when a line is started and compared when valid appears.
module tb_mode7_scanline_setup;
    localparam int CW = 29;
    localparam int EW = 36;
    localparam int SW = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mode7_scanline_setup_if #(.CW(CW), .EW(EW), .SW(SW)) bus();

    mode7_scanline_setup dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { longint au, av, bu, bv, cu, cv, du, dv; } corners_t;
    typedef struct { longint cyc, lu, lv, ru, rv, su, sv; } exp_t;

    exp_t   sb[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    longint cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic longint sx(input longint x, input int w);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic exp_t model(input corners_t k, input longint oy, input longint n);
        exp_t e;
        e.cyc = n + 7;
        e.lu  = sx(k.cu + ((k.au - k.cu) >>> 16) * oy, EW);
        e.lv  = sx(k.cv + ((k.av - k.cv) >>> 16) * oy, EW);
        e.ru  = sx(k.du + ((k.bu - k.du) >>> 16) * oy, EW);
        e.rv  = sx(k.dv + ((k.bv - k.dv) >>> 16) * oy, EW);
        e.su  = sx(((e.ru - e.lu) * 102) >>> 16, SW);
        e.sv  = sx(((e.rv - e.lv) * 102) >>> 16, SW);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("valid_in_reset", longint'(bus.valid), 0);
        end else if (bus.valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", longint'(bus.valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("left_u",   longint'(bus.left_u),   e.lu);
                chk("left_v",   longint'(bus.left_v),   e.lv);
                chk("right_u",  longint'(bus.right_u),  e.ru);
                chk("right_v",  longint'(bus.right_v),  e.rv);
                chk("u_stride", longint'(bus.u_stride), e.su);
                chk("v_stride", longint'(bus.v_stride), e.sv);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input corners_t k);
        bus.a_u = CW'(k.au); bus.a_v = CW'(k.av);
        bus.b_u = CW'(k.bu); bus.b_v = CW'(k.bv);
        bus.c_u = CW'(k.cu); bus.c_v = CW'(k.cv);
        bus.d_u = CW'(k.du); bus.d_v = CW'(k.dv);
    endtask

    task automatic load(input corners_t k);
        put(k);
        bus.frame_load = 1'b1;
        tick();
        bus.frame_load = 1'b0;
    endtask

    task automatic line(input corners_t k, input longint oy);
        bus.start      = 1'b1;
        bus.one_over_y = 17'(oy);
        sb.push_back(model(k, oy, cyc));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic load_line(input corners_t k, input longint oy);
        put(k);
        bus.frame_load = 1'b1;
        line(k, oy);
        bus.frame_load = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && (sb.size() != 0 || bus.busy); i++) tick();
        chk("drain_pending", longint'(sb.size()), 0);
        tick();
    endtask

    initial begin
        corners_t k, k_old, k_mid, k_new;
        longint n;

        k = '{default: 0};
        put(k);
        bus.frame_load = 1'b0;
        bus.one_over_y = '0;

        // reset held with start asserted
        rst = 1'b1;
        bus.start = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("rst_busy",    longint'(bus.busy),    0);
        chk("rst_left_u",  longint'(bus.left_u),  0);
        chk("rst_right_v", longint'(bus.right_v), 0);
        chk("rst_stride",  longint'(bus.u_stride), 0);
        bus.start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("post_rst_busy", longint'(bus.busy), 0);

        // basic u interpolation and stride
        tick();
        k = '{default: 0};
        k.au = 262144;
        k.bu = -262144;
        load(k);
        line(k, 32768);
        wait_done();
        chk("t2_left_u",   longint'(bus.left_u),   131072);
        chk("t2_right_u",  longint'(bus.right_u),  -131072);
        chk("t2_u_stride", longint'(bus.u_stride), -408);
        chk("t2_left_v",   longint'(bus.left_v),   0);

        // floor shift of a -1 difference
        k = '{default: 0};
        k.cu = 100;
        k.au = 99;
        load(k);
        line(k, 65535);
        wait_done();
        chk("t3_left_u", longint'(bus.left_u), -65435);

        // one_over_y = 0 returns the near corners
        k = '{au: 5000000, av: -7000000, bu: 123456, bv: 654321,
              cu: -333333, cv: 444444, du: 1000, dv: -2000};
        load(k);
        line(k, 0);
        wait_done();

        // extra starts mid-line and during DONE are ignored
        n = cyc;
        line(k, 20000);
        repeat (2) tick();
        bus.start = 1'b1;
        bus.one_over_y = 17'd999;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.start = 1'b1;
        @(negedge clk);
        chk("t4_busy_done", longint'(bus.busy), 1);
        chk("t4_cycle_done", cyc, n + 7);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("t4_busy_fall", longint'(bus.busy), 0);
        tick();
        wait_done();

        // corner load while busy is deferred; the last of two loads wins
        k_old = '{au: 3000000, av: 1500000, bu: -2500000, bv: 800000,
                  cu: 10000, cv: -20000, du: 30000, dv: -40000};
        k_mid = k_old;
        k_mid.au = -9000000;
        k_new = k_old;
        k_new.au = 12000000;
        load(k_old);
        line(k_old, 50000);
        tick();
        load(k_mid);
        load(k_new);
        wait_done();
        line(k_new, 50000);
        wait_done();

        // reset mid-line aborts; a later frame_load+start in the same cycle works
        k = '{au: 8000000, av: -8000000, bu: 4000000, bv: 2000000,
              cu: -100000, cv: 200000, du: 300000, dv: -400000};
        load(k);
        line(k, 40000);
        repeat (3) tick();
        rst = 1'b1;
        sb.delete(sb.size() - 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_busy",    longint'(bus.busy),     0);
        chk("t6_left_u",  longint'(bus.left_u),   0);
        chk("t6_v_stride", longint'(bus.v_stride), 0);
        repeat (10) tick();
        load_line(k, 40000);
        wait_done();

        // random corners and factors
        for (int i = 0; i < 6; i++) begin
            k.au = longint'($urandom_range(0, 268435455)) - 134217728;
            k.av = longint'($urandom_range(0, 268435455)) - 134217728;
            k.bu = longint'($urandom_range(0, 268435455)) - 134217728;
            k.bv = longint'($urandom_range(0, 268435455)) - 134217728;
            k.cu = longint'($urandom_range(0, 268435455)) - 134217728;
            k.cv = longint'($urandom_range(0, 268435455)) - 134217728;
            k.du = longint'($urandom_range(0, 268435455)) - 134217728;
            k.dv = longint'($urandom_range(0, 268435455)) - 134217728;
            load(k);
            line(k, longint'($urandom_range(0, 131071)));
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
